decode_execute_reg: RTL
=======================

# decode_execute_reg

Decode→Execute pipeline boundary of the processor, sitting directly downstream of `regfile`. It captures the operands `regfile` produces (`RD1D`, `RD2D`) together with the decode-stage control word. It also resolves the same-cycle Writeback→Decode read-after-write case, detects load-use hazards (stalling Decode and inserting a bubble) and squashes the stage on a taken branch. A saturating counter of inserted bubbles is kept for performance debug on `LEDs`/`Switches`-level tooling.

## Interface
Parameters:
- `DATA_W`, 32, datapath width
- `ADDR_W`, 5, register address width
- `CNT_W`, 16, bubble counter width

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `ValidD`  in  1  decode slot holds a real instruction
- `RA1D`, `RA2D`  in  ADDR_W  source addresses, as sent to `regfile`
- `WA3D`  in  ADDR_W  destination address
- `RD1D`, `RD2D`  in  DATA_W  `regfile` read data
- `ExtImmD`  in  DATA_W  extended immediate
- `PCPlus8D`  in  DATA_W  PC+8 of decode instruction
- `TypeD`  in  3  000 reg-ALU, 001 imm-ALU, 100 load, 101 store, others NOP
- `ALUControlD`  in  4  ALU op
- `RegWriteD`, `MemWriteD`, `BranchD`  in  1  control
- `RegWriteW`  in  1  writeback enable, same as `regfile` port
- `WA3W`  in  ADDR_W  writeback address
- `ResultW`  in  DATA_W  writeback data
- `BranchTakenE`  in  1  execute resolved a taken branch
- `FlushExt`  in  1  external flush, e.g. exception/debug
- `ClrCnt`  in  1  synchronous clear of bubble counter
- `StallD`  out  1  combinational: hold Fetch/Decode this cycle
- `ValidE`  out  1  execute slot valid
- `RA1E`, `RA2E`, `WA3E`  out  ADDR_W  registered addresses, for execute forwarding
- `SrcAE`, `SrcBE`, `WriteDataE`  out  DATA_W  registered operands
- `PCPlus8E`  out  DATA_W  registered
- `TypeE`  out  3  registered
- `ALUControlE`  out  4  registered
- `RegWriteE`, `MemWriteE`, `MemToRegE`, `BranchE`  out  1  registered, gated by valid
- `BubbleCnt`  out  CNT_W  saturating count of inserted bubbles

## Operation
Source usage:
- `usesA` = ValidD & TypeD ∈ {000, 001, 100, 101}
- `usesB` = ValidD & TypeD ∈ {000, 101}

W bypass, applied per operand:
- opA = (RegWriteW & WA3W==RA1D) ? ResultW : RD1D; same rule for opB with RA2D/RD2D.
- Register 0 is not special.

Load-use hazard:
- `lu` = ValidE & MemToRegE & RegWriteE & ((usesA & RA1D==WA3E) | (usesB & RA2D==WA3E)).

Flush and stall:
- `flush` = BranchTakenE | FlushExt.
- `StallD` = lu & ~flush. A flush takes precedence, because the decode instruction is wrong-path.

Operand mapping when loading an instruction:
- SrcAE = opA.
- SrcBE = ExtImmD for TypeD ∈ {001, 100, 101}; otherwise opB.
- WriteDataE = opB.
- MemToRegE = (TypeD==100).
- MemWriteE = MemWriteD & (TypeD==101).
- Other fields are copied through.
- TypeD 01x/11x loads as NOP: ValidE=1, all enables 0.

Per clock edge, highest priority first:
1. `rst_n`=0: bubble.
2. `flush`: bubble.
3. `lu`: bubble.
4. Otherwise: load decode values, with ValidE=ValidD and control gated by ValidD.

Bubble:
- ValidE=0.
- RegWriteE, MemWriteE, MemToRegE, BranchE = 0.
- TypeE=111.
- Data and address fields go to 0.

BubbleCnt:
- Increments by 1 on each edge where case 2 or 3 applies and `rst_n`=1.
- Saturates at all-ones.
- ClrCnt=1 forces it to 0 and wins over increment.

## Timing
- Reset values: ValidE=0, all enables 0, TypeE=111, all data/address outputs 0, BubbleCnt=0, StallD=0.
- Reset is asynchronous assert, and releases on the next rising edge.
- Latency: one cycle, Decode inputs to E outputs.
- StallD is combinational and valid in the same cycle as the hazard.
  - Upstream must hold RA*/RD*/control stable while StallD=1.
  - A load-use hazard causes exactly one stall cycle, because the following cycle's ValidE=0 clears `lu`.
- Bypass uses W values in the same cycle, so `regfile` write-then-read ordering is not required.
- Reset asserted mid-stall: StallD drops immediately, and the stage is a bubble until release.
- Simultaneous BranchTakenE and lu: bubble, StallD=0, counter +1 (not +2).

## Test plan
1. Reset with all inputs nonzero.
   - During reset: ValidE=0, TypeE=111, SrcAE=0, BubbleCnt=0.
   - After release, ValidD=1, TypeD=000, RD1D=0x11, RD2D=0x22, WA3D=3: next edge gives SrcAE=0x11, SrcBE=0x22, RegWriteE=RegWriteD.
2. W bypass.
   - Stimulus: RA1D=5, RD1D=0xAAAA, RegWriteW=1, WA3W=5, ResultW=0x1234.
   - Required: SrcAE=0x1234.
   - With RegWriteW=0: SrcAE=0xAAAA.
3. Load-use.
   - Load r4 (TypeD=100, WA3D=4, ExtImmD=0x10, RegWriteD=1) is in E; D is TypeD=000 with RA2D=4.
   - Required: StallD=1 for one cycle, next ValidE=0, BubbleCnt=1.
   - Following edge loads the consumer.
   - Same consumer with TypeD=001 (RA2D unused): StallD=0.
4. Branch flush with hazard.
   - BranchTakenE=1 together with the load-use case.
   - Required: StallD=0, ValidE=0 next, BubbleCnt +1.
   - FlushExt alone: same bubble.
5. Counter.
   - Preload via 0xFFFF bubbles (CNT_W=16): BubbleCnt stays 0xFFFF.
   - ClrCnt=1 together with a flush: BubbleCnt=0.
6. Store mapping.
   - TypeD=101, RD2D=0xBEEF, ExtImmD=8, MemWriteD=1.
   - Required: SrcBE=8, WriteDataE=0xBEEF, MemWriteE=1, MemToRegE=0.

Source files
------------

// File: rtl/decode_execute_reg.sv
// Decode->Execute pipeline register with same-cycle Writeback bypass,
// load-use stall/bubble insertion, branch squash and a saturating bubble counter.
module decode_execute_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ValidD,
  input  logic [ADDR_W-1:0] RA1D,
  input  logic [ADDR_W-1:0] RA2D,
  input  logic [ADDR_W-1:0] WA3D,
  input  logic [DATA_W-1:0] RD1D,
  input  logic [DATA_W-1:0] RD2D,
  input  logic [DATA_W-1:0] ExtImmD,
  input  logic [DATA_W-1:0] PCPlus8D,
  input  logic [2:0]        TypeD,
  input  logic [3:0]        ALUControlD,
  input  logic              RegWriteD,
  input  logic              MemWriteD,
  input  logic              BranchD,
  input  logic              RegWriteW,
  input  logic [ADDR_W-1:0] WA3W,
  input  logic [DATA_W-1:0] ResultW,
  input  logic              BranchTakenE,
  input  logic              FlushExt,
  input  logic              ClrCnt,
  output logic              StallD,
  output logic              ValidE,
  output logic [ADDR_W-1:0] RA1E,
  output logic [ADDR_W-1:0] RA2E,
  output logic [ADDR_W-1:0] WA3E,
  output logic [DATA_W-1:0] SrcAE,
  output logic [DATA_W-1:0] SrcBE,
  output logic [DATA_W-1:0] WriteDataE,
  output logic [DATA_W-1:0] PCPlus8E,
  output logic [2:0]        TypeE,
  output logic [3:0]        ALUControlE,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              MemToRegE,
  output logic              BranchE,
  output logic [CNT_W-1:0]  BubbleCnt
);

  localparam logic [2:0] T_REG   = 3'b000;
  localparam logic [2:0] T_IMM   = 3'b001;
  localparam logic [2:0] T_LOAD  = 3'b100;
  localparam logic [2:0] T_STORE = 3'b101;
  localparam logic [2:0] T_NOP   = 3'b111;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [ADDR_W-1:0] wa3;
    logic [DATA_W-1:0] srca;
    logic [DATA_W-1:0] srcb;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] pc8;
    logic [2:0]        typ;
    logic [3:0]        aluc;
    logic              rw;
    logic              mw;
    logic              m2r;
    logic              br;
  } e_t;

  localparam e_t BUBBLE = '{valid: 1'b0, ra1: '0, ra2: '0, wa3: '0,
                            srca: '0, srcb: '0, wd: '0, pc8: '0,
                            typ: T_NOP, aluc: '0,
                            rw: 1'b0, mw: 1'b0, m2r: 1'b0, br: 1'b0};

  e_t                e_q;
  e_t                e_load;
  logic              known_type;
  logic              uses_a;
  logic              uses_b;
  logic              lu;
  logic              flush;
  logic              bubble;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [CNT_W-1:0]  cnt_q;

  assign known_type = (TypeD == T_REG) | (TypeD == T_IMM) | (TypeD == T_LOAD) | (TypeD == T_STORE);
  assign uses_a     = ValidD & known_type;
  assign uses_b     = ValidD & ((TypeD == T_REG) | (TypeD == T_STORE));

  // Writeback bypass covers the regfile write/read in the same cycle.
  assign op_a = (RegWriteW && (WA3W == RA1D)) ? ResultW : RD1D;
  assign op_b = (RegWriteW && (WA3W == RA2D)) ? ResultW : RD2D;

  assign lu     = e_q.valid & e_q.m2r & e_q.rw &
                  ((uses_a & (RA1D == e_q.wa3)) | (uses_b & (RA2D == e_q.wa3)));
  assign flush  = BranchTakenE | FlushExt;
  assign bubble = flush | lu;
  // A wrong-path decode instruction must not hold the front end.
  assign StallD = lu & ~flush;

  always_comb begin
    // NOTE: a full default first keeps every field assigned on every path, so no latch is inferred.
    e_load       = BUBBLE;
    e_load.valid = ValidD;
    e_load.ra1   = RA1D;
    e_load.ra2   = RA2D;
    e_load.wa3   = WA3D;
    e_load.srca  = op_a;
    e_load.srcb  = (TypeD == T_IMM || TypeD == T_LOAD || TypeD == T_STORE) ? ExtImmD : op_b;
    e_load.wd    = op_b;
    e_load.pc8   = PCPlus8D;
    e_load.typ   = TypeD;
    e_load.aluc  = ALUControlD;
    e_load.rw    = ValidD & known_type & RegWriteD;
    e_load.mw    = ValidD & MemWriteD & (TypeD == T_STORE);
    e_load.m2r   = ValidD & (TypeD == T_LOAD);
    e_load.br    = ValidD & known_type & BranchD;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      e_q <= BUBBLE;
    else if (bubble) e_q <= BUBBLE;
    else             e_q <= e_load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt_q <= '0;
    else if (ClrCnt)               cnt_q <= '0;
    else if (bubble && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign ValidE      = e_q.valid;
  assign RA1E        = e_q.ra1;
  assign RA2E        = e_q.ra2;
  assign WA3E        = e_q.wa3;
  assign SrcAE       = e_q.srca;
  assign SrcBE       = e_q.srcb;
  assign WriteDataE  = e_q.wd;
  assign PCPlus8E    = e_q.pc8;
  assign TypeE       = e_q.typ;
  assign ALUControlE = e_q.aluc;
  assign RegWriteE   = e_q.rw;
  assign MemWriteE   = e_q.mw;
  assign MemToRegE   = e_q.m2r;
  assign BranchE     = e_q.br;
  assign BubbleCnt   = cnt_q;

endmodule
